// File: rtl/sysctrl_pkg.sv
// Shared definitions for the system-control link: command codes, config ids,
// status magic bytes and the initiator FSM state encoding.
package sysctrl_pkg;

    localparam logic [7:0] CMD_STATUS  = 8'd0;
    localparam logic [7:0] CMD_LEDS    = 8'd1;
    localparam logic [7:0] CMD_COLOR   = 8'd2;
    localparam logic [7:0] CMD_BUTTONS = 8'd3;
    localparam logic [7:0] CMD_CONFIG  = 8'd4;
    localparam logic [7:0] CMD_INT_ACK = 8'd5;
    localparam logic [7:0] CMD_INT_SRC = 8'd6;
    localparam logic [7:0] CMD_PORT    = 8'd7;
    localparam logic [7:0] CMD_MENU    = 8'd8;

    localparam logic [7:0] CFG_ID_R = "R";
    localparam logic [7:0] CFG_ID_Y = "Y";
    localparam logic [7:0] CFG_ID_W = "W";
    localparam logic [7:0] CFG_ID_X = "X";
    localparam logic [7:0] CFG_ID_S = "S";

    localparam logic [7:0] STATUS_MAGIC_LO = 8'h5c;
    localparam logic [7:0] STATUS_MAGIC_HI = 8'h42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT,
        ST_BYTE,
        ST_TAIL,
        ST_DONE
    } init_state_e;

    // Requested payload length limited to what the initiator can buffer.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/sysctrl_initiator_if.sv
// Request/response and byte-link signals of the system-control initiator.
// The slave modport is the initiator itself; master is its user plus responder.
interface sysctrl_initiator_if;

    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [3:0]  req_len;
    logic [63:0] req_payload;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        busy;
    logic        data_out_strobe;
    logic        data_out_start;
    logic [7:0]  data_out;
    logic [7:0]  data_in;

    modport master (
        output req_valid, req_cmd, req_len, req_payload, data_in,
        input  req_ready, rsp_valid, rsp_data, busy,
               data_out_strobe, data_out_start, data_out
    );

    modport slave (
        input  req_valid, req_cmd, req_len, req_payload, data_in,
        output req_ready, rsp_valid, rsp_data, busy,
               data_out_strobe, data_out_start, data_out
    );

endinterface

// File: rtl/sysctrl_initiator.sv
// Initiating end of the byte-framed system-control link. Sends a command byte
// plus up to PAYLOAD_MAX payload bytes at STROBE_GAP spacing and gathers the
// responder's byte-wise answers into rsp_data. All outputs are registered.
module sysctrl_initiator
    import sysctrl_pkg::*;
#(
    parameter int STROBE_GAP  = 4,
    parameter int PAYLOAD_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    sysctrl_initiator_if.slave  bus
);

    // WAIT lasts STROBE_GAP-1 cycles; the counter runs down to zero inclusive.
    localparam logic [7:0] GAP_LOAD = 8'(STROBE_GAP - 2);
    localparam logic [3:0] MAX_LEN  = 4'(PAYLOAD_MAX);

    init_state_e state_q, state_d;
    logic [3:0]  remain_q, remain_d;
    logic [2:0]  idx_q, idx_d;
    logic [63:0] payload_q, payload_d;
    logic [7:0]  gap_q, gap_d;
    logic        capture_q, capture_d;
    logic [2:0]  cap_idx_q, cap_idx_d;
    logic        req_ready_q, req_ready_d;
    logic        busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic        strobe_q, strobe_d;
    logic        start_q, start_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        accept;

    assign accept = bus.req_valid && req_ready_q;

    // Next-state logic; byte outputs are set on the transition into CMD/BYTE so
    // that the registered strobe lines up with the state it belongs to. The
    // command byte needs no separate latch: data_out_q itself holds it.
    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        idx_d      = idx_q;
        payload_d  = payload_q;
        gap_d      = gap_q;
        capture_d  = (state_q == ST_BYTE);
        cap_idx_d  = idx_q;
        rsp_data_d = rsp_data_q;
        strobe_d   = 1'b0;
        start_d    = 1'b0;
        data_out_d = data_out_q;

        if (capture_q) begin
            rsp_data_d[{cap_idx_q, 3'b000} +: 8] = bus.data_in;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d    = ST_CMD;
                    remain_d   = clamp_len(bus.req_len, MAX_LEN);
                    idx_d      = 3'd0;
                    payload_d  = bus.req_payload;
                    rsp_data_d = '0;
                    strobe_d   = 1'b1;
                    start_d    = 1'b1;
                    data_out_d = bus.req_cmd;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (remain_q == 4'd0) begin
                    state_d = ST_TAIL;
                end else begin
                    state_d = ST_WAIT;
                    gap_d   = GAP_LOAD;
                end
            end
            ST_WAIT: begin
                if (gap_q == 8'd0) begin
                    state_d    = ST_BYTE;
                    strobe_d   = 1'b1;
                    data_out_d = payload_q[{idx_q, 3'b000} +: 8];
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            ST_BYTE: begin
                remain_d = remain_q - 4'd1;
                if (remain_q == 4'd1) begin
                    state_d = ST_TAIL;
                end else begin
                    state_d = ST_WAIT;
                    gap_d   = GAP_LOAD;
                    idx_d   = idx_q + 3'd1;
                end
            end
            ST_TAIL: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remain_q    <= 4'd0;
            idx_q       <= 3'd0;
            payload_q   <= '0;
            gap_q       <= 8'd0;
            capture_q   <= 1'b0;
            cap_idx_q   <= 3'd0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            strobe_q    <= 1'b0;
            start_q     <= 1'b0;
            data_out_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            idx_q       <= idx_d;
            payload_q   <= payload_d;
            gap_q       <= gap_d;
            capture_q   <= capture_d;
            cap_idx_q   <= cap_idx_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            strobe_q    <= strobe_d;
            start_q     <= start_d;
            data_out_q  <= data_out_d;
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.busy            = busy_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_data        = rsp_data_q;
    assign bus.data_out_strobe = strobe_q;
    assign bus.data_out_start  = start_q;
    assign bus.data_out        = data_out_q;

endmodule
